ipsxe_floating_point_align_add_single_v1_0: RTL



---
 rtl/ipsxe_floating_point_align_add_single_v1_0.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ipsxe_floating_point_align_add_single_v1_0.sv
// ---------------------------------------------------------------------------
// ipsxe_floating_point_align_add_single_v1_0
//
// Align-and-add stage of a fused multiply-add. It adds an unrounded product
// a*b to an IEEE addend c and hands the unnormalised sum to the round stage.
//
// Pipeline (every register advances only when i_aclken is high):
//   stage 1 : convert c, order the operands by magnitude, compute the shift
//   stage 2 : right-align the smaller mantissa, jam shifted-out bits as sticky
//   stage 3 : add or subtract the mantissas
//
// Handshake: i_valid/o_valid are qualifiers only. There is no ready signal
// and no backpressure. An item presented with i_valid=1 on an enabled edge
// appears with o_valid=1 exactly three enabled edges later. The datapath
// loads on every enabled edge whatever i_valid is; valid and user ride in a
// parallel three-deep chain.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_aclken         clock enable, low freezes every register
//   i_valid          product/addend pair valid
//   i_prod_sign      sign of a*b
//   i_prod_exp       ea+eb, double-biased, EXP_WIDTH+1 bits
//   i_prod_man       ma*mb, binary point between bits 2*MAN_WIDTH and 2*MAN_WIDTH-1
//   i_c              addend, IEEE format
//   i_user           sideband, delayed with the data
//   o_valid          o_add_out valid
//   o_add_out        {sign, exponent[EXP_WIDTH:0], mantissa[2*(MAN_WIDTH+1):0]}
//   o_user           i_user aligned with o_valid
// ---------------------------------------------------------------------------
module ipsxe_floating_point_align_add_single_v1_0 #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int W_USER    = 1
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst_n,
  input  logic                                               i_aclken,
  input  logic                                               i_valid,
  input  logic                                               i_prod_sign,
  input  logic [EXP_WIDTH:0]                                 i_prod_exp,
  input  logic [2*(MAN_WIDTH+1)-1:0]                         i_prod_man,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]                       i_c,
  input  logic [W_USER-1:0]                                  i_user,
  output logic                                               o_valid,
  output logic [(2*(MAN_WIDTH+1)+1)+(EXP_WIDTH+1)+1-1:0]     o_add_out,
  output logic [W_USER-1:0]                                  o_user
);

  localparam int PW    = 2 * (MAN_WIDTH + 1);  // aligned mantissa field
  localparam int SW    = PW + 1;               // sum field, room for carry
  localparam int EW1   = EXP_WIDTH + 1;
  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int SHMAX = PW + 1;               // shift saturation value
  localparam int SHW   = $clog2(SHMAX + 1);

  // ---------------- stage 1: convert, order, shift amount ----------------
  logic           s1_sign_l_d, s1_sign_l_q;
  logic           s1_eff_sub_d, s1_eff_sub_q;
  logic [EW1-1:0] s1_exp_l_d, s1_exp_l_q;
  logic [PW-1:0]  s1_man_l_d, s1_man_l_q;
  logic [PW-1:0]  s1_man_s_d, s1_man_s_q;
  logic [SHW-1:0] s1_shift_d, s1_shift_q;

  logic           c_sign;
  logic           c_zero;
  logic           p_zero;
  logic           prod_is_l;
  logic [EW1-1:0] c_exp;
  logic [PW-1:0]  c_man;
  logic [EW1-1:0] exp_s;
  logic [EW1-1:0] exp_diff;
  logic           sign_s;

  always_comb begin
    c_sign = i_c[EXP_WIDTH+MAN_WIDTH];
    c_zero = (i_c[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH] == '0);
    p_zero = (i_prod_man == '0);
    c_exp  = EW1'(i_c[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH]) + EW1'(BIAS);
    // Hidden one lands on bit 2*MAN_WIDTH so c shares the product's binary point.
    c_man  = c_zero ? '0 : {1'b0, 1'b1, i_c[MAN_WIDTH-1:0], {MAN_WIDTH{1'b0}}};

    // A zero operand always goes to the S side; its mantissa is already 0,
    // so whatever shift it receives contributes nothing.
    prod_is_l = c_zero || (!p_zero && ({i_prod_exp, i_prod_man} >= {c_exp, c_man}));

    s1_sign_l_d = prod_is_l ? i_prod_sign : c_sign;
    sign_s      = prod_is_l ? c_sign      : i_prod_sign;
    s1_exp_l_d  = prod_is_l ? i_prod_exp  : c_exp;
    exp_s       = prod_is_l ? c_exp       : i_prod_exp;
    s1_man_l_d  = prod_is_l ? i_prod_man  : c_man;
    s1_man_s_d  = prod_is_l ? c_man       : i_prod_man;
    s1_eff_sub_d = s1_sign_l_d ^ sign_s;

    exp_diff   = s1_exp_l_d - exp_s;
    s1_shift_d = (exp_diff > EW1'(SHMAX)) ? SHW'(SHMAX) : SHW'(exp_diff);
  end

  // ---------------- stage 2: alignment with jamming sticky ----------------
  logic           s2_sign_l_d, s2_sign_l_q;
  logic           s2_eff_sub_d, s2_eff_sub_q;
  logic [EW1-1:0] s2_exp_l_d, s2_exp_l_q;
  logic [PW-1:0]  s2_man_l_d, s2_man_l_q;
  logic [PW-1:0]  s2_man_s_d, s2_man_s_q;

  // The low SW bits catch everything shifted out, even at the saturated shift.
  logic [PW+SW-1:0] align_wide;
  logic             sticky;

  always_comb begin
    align_wide   = {s1_man_s_q, {SW{1'b0}}} >> s1_shift_q;
    sticky       = |align_wide[SW-1:0];
    s2_man_s_d   = {align_wide[PW+SW-1:SW+1], align_wide[SW] | sticky};
    s2_sign_l_d  = s1_sign_l_q;
    s2_eff_sub_d = s1_eff_sub_q;
    s2_exp_l_d   = s1_exp_l_q;
    s2_man_l_d   = s1_man_l_q;
  end

  // ---------------- stage 3: add / subtract ----------------
  logic           s3_sign_d, s3_sign_q;
  logic [EW1-1:0] s3_exp_d, s3_exp_q;
  logic [SW-1:0]  s3_man_d, s3_man_q;

  always_comb begin
    if (s2_eff_sub_q) s3_man_d = {1'b0, s2_man_l_q} - {1'b0, s2_man_s_q};
    else              s3_man_d = {1'b0, s2_man_l_q} + {1'b0, s2_man_s_q};
    // An exact cancellation is reported as +0.
    s3_sign_d = (s2_eff_sub_q && (s3_man_d == '0)) ? 1'b0 : s2_sign_l_q;
    s3_exp_d  = s2_exp_l_q;
  end

  // ---------------- valid / user chain ----------------
  logic [2:0]        vld_d, vld_q;
  logic [W_USER-1:0] user1_d, user1_q;
  logic [W_USER-1:0] user2_d, user2_q;
  logic [W_USER-1:0] user3_d, user3_q;

  always_comb begin
    vld_d   = {vld_q[1:0], i_valid};
    user1_d = i_user;
    user2_d = user1_q;
    user3_d = user2_q;
  end

  // ---------------- registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_sign_l_q  <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_exp_l_q   <= '0;
      s1_man_l_q   <= '0;
      s1_man_s_q   <= '0;
      s1_shift_q   <= '0;
      s2_sign_l_q  <= 1'b0;
      s2_eff_sub_q <= 1'b0;
      s2_exp_l_q   <= '0;
      s2_man_l_q   <= '0;
      s2_man_s_q   <= '0;
      s3_sign_q    <= 1'b0;
      s3_exp_q     <= '0;
      s3_man_q     <= '0;
      vld_q        <= '0;
      user1_q      <= '0;
      user2_q      <= '0;
      user3_q      <= '0;
    end else if (i_aclken) begin
      s1_sign_l_q  <= s1_sign_l_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_exp_l_q   <= s1_exp_l_d;
      s1_man_l_q   <= s1_man_l_d;
      s1_man_s_q   <= s1_man_s_d;
      s1_shift_q   <= s1_shift_d;
      s2_sign_l_q  <= s2_sign_l_d;
      s2_eff_sub_q <= s2_eff_sub_d;
      s2_exp_l_q   <= s2_exp_l_d;
      s2_man_l_q   <= s2_man_l_d;
      s2_man_s_q   <= s2_man_s_d;
      s3_sign_q    <= s3_sign_d;
      s3_exp_q     <= s3_exp_d;
      s3_man_q     <= s3_man_d;
      vld_q        <= vld_d;
      user1_q      <= user1_d;
      user2_q      <= user2_d;
      user3_q      <= user3_d;
    end
  end

  assign o_valid   = vld_q[2];
  assign o_add_out = {s3_sign_q, s3_exp_q, s3_man_q};
  assign o_user    = user3_q;

endmodule
